// File: rtl/usb_uart_bridge.sv
// -----------------------------------------------------------------------------
// usb_uart_bridge
//
// Buffered byte bridge between application logic (valid/ready) and the
// usb_serial core's UART-style strobe handshake. Everything runs on clk.
//
//   TX path: application -> TX FIFO -> drain FSM -> uart_tx_data/uart_tx_strobe
//   RX path: uart_rx_data/uart_rx_strobe -> RX FIFO (FWFT) -> application
//
// Optional build macro: USB_UART_TX_HOLDOFF_EN
//   When defined, the drain FSM only starts a byte while a release flag is set.
//   The flag sets once TX occupancy reaches HOLDOFF_THRESH, or after
//   HOLDOFF_TIMEOUT cycles without a TX push while data is waiting. It clears
//   once the FIFO has drained empty. This lets bytes batch into full USB packets.
//   When undefined, the release flag is tied high and no counter is built.
//
// Ports
//   clk            in   single clock
//   reset          in   asynchronous, active-low reset
//   tx_data        in   application byte to send
//   tx_valid       in   tx_data valid
//   tx_ready       out  TX FIFO can accept (low while in reset)
//   rx_data        out  head of RX FIFO, first-word fall-through
//   rx_valid       out  RX FIFO not empty
//   rx_ready       in   application consumes rx_data
//   uart_tx_data   out  byte to serial core, held until the next strobe
//   uart_tx_strobe out  one-cycle send pulse
//   uart_tx_ready  in   serial core can accept a byte
//   uart_rx_data   in   byte from serial core
//   uart_rx_strobe in   one-cycle receive pulse
//   tx_level       out  registered TX occupancy
//   rx_level       out  registered RX occupancy
//   rx_overflow    out  sticky: an RX byte was dropped
//   rx_drop_count  out  saturating dropped-byte counter
//   clear_stats    in   clears rx_overflow and rx_drop_count (wins over a drop)
// -----------------------------------------------------------------------------
module usb_uart_bridge #(
    parameter int DATA_WIDTH      = 8,
    parameter int TX_DEPTH        = 64,
    parameter int RX_DEPTH        = 64,
    parameter int HOLDOFF_THRESH  = 32,
    parameter int HOLDOFF_TIMEOUT = 4800
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_WIDTH-1:0]       tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic [DATA_WIDTH-1:0]       rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic [DATA_WIDTH-1:0]       uart_tx_data,
    output logic                        uart_tx_strobe,
    input  logic                        uart_tx_ready,
    input  logic [DATA_WIDTH-1:0]       uart_rx_data,
    input  logic                        uart_rx_strobe,
    output logic [$clog2(TX_DEPTH):0]   tx_level,
    output logic [$clog2(RX_DEPTH):0]   rx_level,
    output logic                        rx_overflow,
    output logic [7:0]                  rx_drop_count,
    input  logic                        clear_stats
);

    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);

    localparam logic [TAW:0] TX_ONE = {{TAW{1'b0}}, 1'b1};
    localparam logic [RAW:0] RX_ONE = {{RAW{1'b0}}, 1'b1};

    // Elaboration-time parameter sanity checks.
    if (TX_DEPTH < 4 || (1 << TAW) != TX_DEPTH) begin : g_bad_tx_depth
        $error("usb_uart_bridge: TX_DEPTH must be a power of two >= 4");
    end
    if (RX_DEPTH < 4 || (1 << RAW) != RX_DEPTH) begin : g_bad_rx_depth
        $error("usb_uart_bridge: RX_DEPTH must be a power of two >= 4");
    end
    if (HOLDOFF_THRESH < 1 || HOLDOFF_THRESH > TX_DEPTH || HOLDOFF_TIMEOUT < 1) begin : g_bad_holdoff
        $error("usb_uart_bridge: HOLDOFF_THRESH must be 1..TX_DEPTH and HOLDOFF_TIMEOUT >= 1");
    end

    // -------------------------------------------------------------------------
    // TX FIFO
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] tx_mem [TX_DEPTH];
    logic [TAW:0]          tx_wr_q, tx_wr_d;
    logic [TAW:0]          tx_rd_q, tx_rd_d;
    logic [TAW:0]          tx_level_q, tx_level_d;
    logic                  tx_en_q;          // low until the first edge after reset
    logic                  tx_full, tx_empty;
    logic                  tx_push, tx_pop;
    logic                  tx_release;

    assign tx_empty = (tx_wr_q == tx_rd_q);
    assign tx_full  = (tx_wr_q[TAW] != tx_rd_q[TAW]) &&
                      (tx_wr_q[TAW-1:0] == tx_rd_q[TAW-1:0]);

    // Fullness is judged before any same-cycle drain, so a full FIFO refuses.
    assign tx_ready = tx_en_q && !tx_full;
    assign tx_push  = tx_valid && tx_ready;

    always_comb begin
        tx_wr_d    = tx_wr_q;
        tx_rd_d    = tx_rd_q;
        tx_level_d = tx_level_q;
        if (tx_push) tx_wr_d = tx_wr_q + TX_ONE;
        if (tx_pop)  tx_rd_d = tx_rd_q + TX_ONE;
        case ({tx_push, tx_pop})
            2'b10:   tx_level_d = tx_level_q + TX_ONE;
            2'b01:   tx_level_d = tx_level_q - TX_ONE;
            default: tx_level_d = tx_level_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_wr_q    <= '0;
            tx_rd_q    <= '0;
            tx_level_q <= '0;
            tx_en_q    <= 1'b0;
        end else begin
            tx_wr_q    <= tx_wr_d;
            tx_rd_q    <= tx_rd_d;
            tx_level_q <= tx_level_d;
            tx_en_q    <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_q[TAW-1:0]] <= tx_data;
    end

    assign tx_level = tx_level_q;

    // -------------------------------------------------------------------------
    // TX holdoff (optional)
    // -------------------------------------------------------------------------
`ifdef USB_UART_TX_HOLDOFF_EN
    localparam int ICW = $clog2(HOLDOFF_TIMEOUT + 1);
    localparam logic [ICW-1:0] IDLE_MAX = ICW'(HOLDOFF_TIMEOUT);
    localparam logic [ICW-1:0] IDLE_ONE = ICW'(1);
    localparam logic [TAW:0]   THRESH   = (TAW + 1)'(HOLDOFF_THRESH);

    logic [ICW-1:0] idle_cnt_q, idle_cnt_d;
    logic           release_q, release_d;

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (tx_push)
            idle_cnt_d = '0;
        else if (idle_cnt_q != IDLE_MAX)
            idle_cnt_d = idle_cnt_q + IDLE_ONE;

        release_d = release_q;
        if (tx_level_q == '0)
            release_d = 1'b0;
        else if (tx_level_q >= THRESH || idle_cnt_q == IDLE_MAX)
            release_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt_q <= '0;
            release_q  <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            release_q  <= release_d;
        end
    end

    assign tx_release = release_q;
`else
    assign tx_release = 1'b1;
`endif

    // -------------------------------------------------------------------------
    // TX drain FSM
    // -------------------------------------------------------------------------
    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } tx_state_e;

    tx_state_e             tx_state_q, tx_state_d;
    logic [DATA_WIDTH-1:0] uart_tx_data_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            ST_IDLE: begin
                if (uart_tx_ready && !tx_empty && tx_release) begin
                    tx_pop     = 1'b1;
                    tx_state_d = ST_SEND;
                end
            end
            ST_SEND: tx_state_d = ST_IDLE;
            default: tx_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q     <= ST_IDLE;
            uart_tx_data_q <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            if (tx_pop) uart_tx_data_q <= tx_mem[tx_rd_q[TAW-1:0]];
        end
    end

    // The strobe is the SEND state itself: one cycle wide, at most every 2nd cycle.
    assign uart_tx_strobe = (tx_state_q == ST_SEND);
    assign uart_tx_data   = uart_tx_data_q;

    // -------------------------------------------------------------------------
    // RX FIFO
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] rx_mem [RX_DEPTH];
    logic [RAW:0]          rx_wr_q, rx_wr_d;
    logic [RAW:0]          rx_rd_q, rx_rd_d;
    logic [RAW:0]          rx_level_q, rx_level_d;
    logic                  rx_full, rx_empty;
    logic                  rx_push, rx_pop, rx_drop;
    logic                  rx_overflow_q, rx_overflow_d;
    logic [7:0]            rx_drop_cnt_q, rx_drop_cnt_d;

    assign rx_empty = (rx_wr_q == rx_rd_q);
    assign rx_full  = (rx_wr_q[RAW] != rx_rd_q[RAW]) &&
                      (rx_wr_q[RAW-1:0] == rx_rd_q[RAW-1:0]);

    assign rx_push = uart_rx_strobe && !rx_full;
    assign rx_drop = uart_rx_strobe &&  rx_full;
    assign rx_pop  = !rx_empty && rx_ready;

    always_comb begin
        rx_wr_d    = rx_wr_q;
        rx_rd_d    = rx_rd_q;
        rx_level_d = rx_level_q;
        if (rx_push) rx_wr_d = rx_wr_q + RX_ONE;
        if (rx_pop)  rx_rd_d = rx_rd_q + RX_ONE;
        case ({rx_push, rx_pop})
            2'b10:   rx_level_d = rx_level_q + RX_ONE;
            2'b01:   rx_level_d = rx_level_q - RX_ONE;
            default: rx_level_d = rx_level_q;
        endcase

        rx_overflow_d = rx_overflow_q;
        rx_drop_cnt_d = rx_drop_cnt_q;
        if (clear_stats) begin
            rx_overflow_d = 1'b0;
            rx_drop_cnt_d = '0;
        end else if (rx_drop) begin
            rx_overflow_d = 1'b1;
            if (rx_drop_cnt_q != 8'hFF) rx_drop_cnt_d = rx_drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_wr_q       <= '0;
            rx_rd_q       <= '0;
            rx_level_q    <= '0;
            rx_overflow_q <= 1'b0;
            rx_drop_cnt_q <= '0;
        end else begin
            rx_wr_q       <= rx_wr_d;
            rx_rd_q       <= rx_rd_d;
            rx_level_q    <= rx_level_d;
            rx_overflow_q <= rx_overflow_d;
            rx_drop_cnt_q <= rx_drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_q[RAW-1:0]] <= uart_rx_data;
    end

    // Masked while empty so the output reads 0 in reset rather than stale storage.
    assign rx_valid      = !rx_empty;
    assign rx_data       = rx_empty ? '0 : rx_mem[rx_rd_q[RAW-1:0]];
    assign rx_level      = rx_level_q;
    assign rx_overflow   = rx_overflow_q;
    assign rx_drop_count = rx_drop_cnt_q;

endmodule

// File: doc/usb_uart_bridge.md
Name: usb_uart_bridge

Overview:
- Parametrised, buffered byte bridge between application logic and the usb_serial core's UART-style handshake, all in the `clk` domain.
- Adds a configurable-depth TX FIFO and a new RX FIFO; RX bytes from the host were previously unbuffered.
- Application side uses valid/ready. Exposes fill levels and RX overflow accounting.
- Sits where the single hard-coded TX FIFO sat. The PHY/SB_IO wrapper instantiates it in front of usb_serial.

Parameters:
- DATA_WIDTH, 8, bits per entry on both paths.
- TX_DEPTH, 64, TX FIFO entries; power of two, ≥4.
- RX_DEPTH, 64, RX FIFO entries; power of two, ≥4.
- HOLDOFF_THRESH, 32, TX level that releases a held burst (USB_UART_TX_HOLDOFF_EN only); 1..TX_DEPTH.
- HOLDOFF_TIMEOUT, 4800, clk cycles of TX inactivity that release a held burst (USB_UART_TX_HOLDOFF_EN only); ≥1.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-low reset.
- tx_data  in  DATA_WIDTH  application byte to send.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  TX FIFO not full.
- rx_data  out  DATA_WIDTH  head of RX FIFO (first-word fall-through).
- rx_valid  out  1  RX FIFO not empty.
- rx_ready  in  1  application consumes rx_data.
- uart_tx_data  out  DATA_WIDTH  byte to serial core.
- uart_tx_strobe  out  1  one-cycle send pulse.
- uart_tx_ready  in  1  serial core can accept a byte.
- uart_rx_data  in  DATA_WIDTH  byte from serial core.
- uart_rx_strobe  in  1  one-cycle receive pulse.
- tx_level  out  $clog2(TX_DEPTH)+1  TX occupancy.
- rx_level  out  $clog2(RX_DEPTH)+1  RX occupancy.
- rx_overflow  out  1  sticky: an RX byte was dropped.
- rx_drop_count  out  8  saturating dropped-byte counter.
- clear_stats  in  1  pulse; clears rx_overflow and rx_drop_count.

Behaviour:
- Reset (reset=0, asynchronous) clears all pointers, levels, counters and outputs, all to 0:
  - tx_ready=0 while reset is asserted and 1 from the first clk edge after release.
  - rx_valid=0, uart_tx_strobe=0, uart_tx_data=0, rx_overflow=0, rx_drop_count=0.
  - A reset mid-burst drops all buffered data immediately; no partial strobe completes.
- FIFOs:
  - Storage is a circular buffer with read/write pointers one bit wider than the address; full and empty are derived from the MSB/address compare.
  - Pointers wrap modulo 2×DEPTH.
  - Levels are registered and reflect the push/pop of the previous edge.
- TX push:
  - Occurs when tx_valid && tx_ready. tx_ready = !tx_full, evaluated before any same-cycle pop.
  - A full FIFO refuses the push even if a drain happens that cycle.
- TX drain FSM, states IDLE and SEND:
  - IDLE→SEND when uart_tx_ready && !tx_empty (&& release when holdoff is enabled). On that edge, uart_tx_data <= head, head popped, uart_tx_strobe=1 for exactly one cycle.
  - SEND→IDLE unconditionally.
  - Minimum spacing between strobes is 2 cycles. Latency from push into an empty FIFO to strobe is 2 cycles when uart_tx_ready=1.
  - uart_tx_data holds its value until the next strobe.
- RX push:
  - On uart_rx_strobe, store uart_rx_data if !rx_full, with fullness evaluated before any same-cycle pop.
  - Otherwise drop the byte, set rx_overflow, and increment rx_drop_count (saturates at 255).
- RX pop: on rx_valid && rx_ready. rx_data is valid whenever rx_valid=1 and is stable until popped.
- Simultaneous push and pop on a non-full, non-empty FIFO: level is unchanged.
- clear_stats and a drop in the same cycle: clear wins; count=0, flag=0.

Optional Feature:
- USB_UART_TX_HOLDOFF_EN defined:
  - Adds a release flag and an idle counter, cleared on every TX push.
  - Release is set when tx_level ≥ HOLDOFF_THRESH, or when the idle counter reaches HOLDOFF_TIMEOUT with tx_level>0.
  - Release clears when the FIFO drains empty. Drain FSM leaves IDLE only while release=1.
  - Purpose: batch bytes into full USB packets.
- Undefined: release is tied to 1, no counter logic is built, and behaviour is exactly as above.

Test Plan:
- Reset release, idle inputs -> tx_ready=1 on first edge; rx_valid=0, levels 0, uart_tx_strobe never asserts.
- Push 0x41,0x42,0x43 back-to-back, uart_tx_ready=1 -> strobes on cycles 2,4,6 after first push carrying 0x41,0x42,0x43; tx_level returns to 0.
- uart_tx_ready=0, push TX_DEPTH bytes -> tx_ready=0 and tx_level=64; 65th tx_valid ignored; raise uart_tx_ready -> exactly 64 strobes in order.
- 66 uart_rx_strobe bytes with rx_ready=0 -> rx_level=64, rx_overflow=1, rx_drop_count=2; pop yields the first 64 bytes in order; clear_stats -> 0/0.
- 300 drops -> rx_drop_count=255; assert reset mid-burst -> all outputs 0 immediately, FIFO contents discarded.
- With USB_UART_TX_HOLDOFF_EN, THRESH=4, TIMEOUT=10: push 3 bytes -> no strobe for 10 idle cycles, then 3 strobes; push 4 bytes -> strobes begin without waiting.
